// File: rtl/controlador_cajero_param_pkg.sv
// Shared definitions for the ATM controller: state encodings, transaction
// type codes and default parameter values.
package controlador_cajero_param_pkg;

  typedef enum logic [2:0] {
    ESPERANDO_TARJETA = 3'd0,
    INGRESANDO_PIN    = 3'd1,
    VERIFICANDO_PIN   = 3'd2,
    ESPERANDO_MONTO   = 3'd3,
    PROCESANDO        = 3'd4,
    BLOQUEADO         = 3'd5
  } estado_t;

  localparam logic TRANS_DEPOSITO = 1'b0;
  localparam logic TRANS_RETIRO   = 1'b1;

  localparam int DEF_N_DIGITOS     = 4;
  localparam int DEF_MAX_INTENTOS  = 3;
  localparam int DEF_ANCHO_MONTO   = 32;
  localparam int DEF_ANCHO_BALANCE = 64;
  localparam int DEF_COMISION_VAL  = 500;

endpackage

// File: rtl/controlador_cajero_param_detector_flanco.sv
// Rising-edge detector: flags a strobe that is sampled high after a low sample,
// so a strobe held high is reported only once.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic flanco
);

  logic previo;

  // remember the previous sample of the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      previo <= 1'b0;
    end else begin
      previo <= entrada;
    end
  end

  assign flanco = entrada & ~previo;

endmodule

// File: rtl/controlador_cajero_param.sv
// ATM session controller: card detection, PIN entry and verification with
// lockout, and deposit/withdrawal processing on a saturating balance.
// Optional macro CONTROLADOR_COMISION_EN enables the per-transaction fee on
// foreign cards; without it the fee is always zero and comision never pulses.
module controlador_cajero_param
  import controlador_cajero_param_pkg::*;
#(
  parameter int                        N_DIGITOS       = DEF_N_DIGITOS,
  parameter int                        MAX_INTENTOS    = DEF_MAX_INTENTOS,
  parameter int                        ANCHO_MONTO     = DEF_ANCHO_MONTO,
  parameter int                        ANCHO_BALANCE   = DEF_ANCHO_BALANCE,
  parameter int                        COMISION_VAL    = DEF_COMISION_VAL,
  parameter logic [ANCHO_BALANCE-1:0]  BALANCE_INICIAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tarjeta_recibida,
  input  logic                     tipo_de_tarjeta,
  input  logic [4*N_DIGITOS-1:0]   pin,
  input  logic [3:0]               digito,
  input  logic                     digito_stb,
  input  logic                     tipo_trans,
  input  logic [ANCHO_MONTO-1:0]   monto,
  input  logic                     monto_stb,
  output logic                     balance_actualizado,
  output logic                     entregar_dinero,
  output logic                     fondos_insuficientes,
  output logic                     pin_incorrecto,
  output logic                     comision,
  output logic                     advertencia,
  output logic                     bloqueo,
  output logic [ANCHO_BALANCE-1:0] balance
);

  localparam int PIN_W = 4 * N_DIGITOS;
  localparam int CNT_W = $clog2(N_DIGITOS + 1);
  localparam int BW    = ANCHO_BALANCE;

`ifdef CONTROLADOR_COMISION_EN
  localparam logic COMISION_EN = 1'b1;
`else
  localparam logic COMISION_EN = 1'b0;
`endif

  estado_t          estado, estado_sig;
  logic [CNT_W-1:0] cnt, cnt_sig;
  logic [PIN_W-1:0] buf_pin, buf_sig;
  logic [3:0]       intentos, intentos_sig, intentos_inc;
  logic [BW-1:0]    monto_lat, monto_sig, fee_lat, fee_sig, balance_sig, fee_actual;
  logic             tipo_lat, tipo_sig, adv_sig, bloq_sig;
  logic             act_sig, entregar_sig, fondos_sig, pinbad_sig, com_sig;
  logic [BW:0]      suma, resta_dep, necesario;
  logic             digito_flanco, monto_flanco;

  detector_flanco u_flanco_digito (
    .clk     (clk),
    .rst     (rst),
    .entrada (digito_stb),
    .flanco  (digito_flanco)
  );

  detector_flanco u_flanco_monto (
    .clk     (clk),
    .rst     (rst),
    .entrada (monto_stb),
    .flanco  (monto_flanco)
  );

  assign fee_actual   = (COMISION_EN && tipo_de_tarjeta) ? BW'(COMISION_VAL) : '0;
  assign intentos_inc = intentos + 4'd1;

  // next state, datapath updates and next values of the registered outputs
  always_comb begin
    estado_sig   = estado;
    cnt_sig      = cnt;
    buf_sig      = buf_pin;
    intentos_sig = intentos;
    monto_sig    = monto_lat;
    tipo_sig     = tipo_lat;
    fee_sig      = fee_lat;
    balance_sig  = balance;
    adv_sig      = advertencia;
    bloq_sig     = bloqueo;
    act_sig      = 1'b0;
    entregar_sig = 1'b0;
    fondos_sig   = 1'b0;
    pinbad_sig   = 1'b0;
    com_sig      = 1'b0;
    suma         = {1'b0, balance} + {1'b0, monto_lat};
    resta_dep    = suma - {1'b0, fee_lat};
    necesario    = {1'b0, monto_lat} + {1'b0, fee_lat};

    case (estado)
      ESPERANDO_TARJETA: begin
        if (tarjeta_recibida) begin
          estado_sig = INGRESANDO_PIN;
          cnt_sig    = '0;
        end else begin
          estado_sig = ESPERANDO_TARJETA;
        end
      end
      INGRESANDO_PIN: begin
        if (!tarjeta_recibida) begin
          estado_sig = ESPERANDO_TARJETA;
          cnt_sig    = '0;
        end else if (digito_flanco) begin
          // shifting left leaves the first digit in the top nibble
          buf_sig = PIN_W'({buf_pin, digito});
          cnt_sig = cnt + CNT_W'(1);
          if (cnt == CNT_W'(N_DIGITOS - 1)) begin
            estado_sig = VERIFICANDO_PIN;
          end else begin
            estado_sig = INGRESANDO_PIN;
          end
        end else begin
          estado_sig = INGRESANDO_PIN;
        end
      end
      VERIFICANDO_PIN: begin
        cnt_sig = '0;
        if (!tarjeta_recibida) begin
          estado_sig = ESPERANDO_TARJETA;
        end else if (buf_pin == pin) begin
          intentos_sig = '0;
          adv_sig      = 1'b0;
          estado_sig   = ESPERANDO_MONTO;
        end else begin
          pinbad_sig   = 1'b1;
          intentos_sig = intentos_inc;
          if (intentos_inc >= 4'(MAX_INTENTOS)) begin
            estado_sig = BLOQUEADO;
            bloq_sig   = 1'b1;
          end else begin
            estado_sig = INGRESANDO_PIN;
          end
          if (intentos_inc >= 4'(MAX_INTENTOS - 1)) begin
            adv_sig = 1'b1;
          end else begin
            adv_sig = advertencia;
          end
        end
      end
      ESPERANDO_MONTO: begin
        if (!tarjeta_recibida) begin
          estado_sig = ESPERANDO_TARJETA;
        end else if (monto_flanco) begin
          monto_sig  = BW'(monto);
          tipo_sig   = tipo_trans;
          fee_sig    = fee_actual;
          estado_sig = PROCESANDO;
        end else begin
          estado_sig = ESPERANDO_MONTO;
        end
      end
      PROCESANDO: begin
        // a transaction in flight always completes, even if the card left
        estado_sig = ESPERANDO_MONTO;
        case (tipo_lat)
          TRANS_DEPOSITO: begin
            if (suma >= {1'b0, fee_lat}) begin
              act_sig = 1'b1;
              com_sig = (fee_lat != '0);
              if (resta_dep[BW]) begin
                balance_sig = '1;
              end else begin
                balance_sig = resta_dep[BW-1:0];
              end
            end else begin
              fondos_sig = 1'b1;
            end
          end
          TRANS_RETIRO: begin
            if (necesario <= {1'b0, balance}) begin
              act_sig      = 1'b1;
              entregar_sig = 1'b1;
              com_sig      = (fee_lat != '0);
              balance_sig  = balance - necesario[BW-1:0];
            end else begin
              fondos_sig = 1'b1;
            end
          end
          default: begin
            balance_sig = balance;
          end
        endcase
      end
      BLOQUEADO: begin
        estado_sig = BLOQUEADO;
        bloq_sig   = 1'b1;
      end
      default: begin
        estado_sig = ESPERANDO_TARJETA;
        cnt_sig    = '0;
      end
    endcase
  end

  // state, datapath and output registers; reset overrides every event
  always_ff @(posedge clk) begin
    if (rst) begin
      estado               <= ESPERANDO_TARJETA;
      cnt                  <= '0;
      buf_pin              <= '0;
      intentos             <= '0;
      monto_lat            <= '0;
      tipo_lat             <= 1'b0;
      fee_lat              <= '0;
      balance              <= BALANCE_INICIAL;
      advertencia          <= 1'b0;
      bloqueo              <= 1'b0;
      balance_actualizado  <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
      pin_incorrecto       <= 1'b0;
      comision             <= 1'b0;
    end else begin
      estado               <= estado_sig;
      cnt                  <= cnt_sig;
      buf_pin              <= buf_sig;
      intentos             <= intentos_sig;
      monto_lat            <= monto_sig;
      tipo_lat             <= tipo_sig;
      fee_lat              <= fee_sig;
      balance              <= balance_sig;
      advertencia          <= adv_sig;
      bloqueo              <= bloq_sig;
      balance_actualizado  <= act_sig;
      entregar_dinero      <= entregar_sig;
      fondos_insuficientes <= fondos_sig;
      pin_incorrecto       <= pinbad_sig;
      comision             <= com_sig;
    end
  end

endmodule

// File: tb/tb_controlador_cajero_param.sv
// Self-checking bench for controlador_cajero_param: directed table, corner
// sequences and randomized sessions against a transaction-level model.
module tb_controlador_cajero_param;

  localparam int ND   = 4;
  localparam int MAXI = 3;
  localparam int AM   = 16;
  localparam int AB   = 20;
  localparam int FEE  = 500;
  localparam longint unsigned MAXB = (64'd1 << AB) - 64'd1;

`ifdef CONTROLADOR_COMISION_EN
  localparam bit FEE_ON = 1'b1;
`else
  localparam bit FEE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, tarjeta_recibida, tipo_de_tarjeta;
  logic [4*ND-1:0] pin;
  logic [3:0]    digito;
  logic          digito_stb, tipo_trans, monto_stb;
  logic [AM-1:0] monto;
  logic          balance_actualizado, entregar_dinero, fondos_insuficientes;
  logic          pin_incorrecto, comision, advertencia, bloqueo;
  logic [AB-1:0] balance;

  controlador_cajero_param #(
    .N_DIGITOS     (ND),
    .MAX_INTENTOS  (MAXI),
    .ANCHO_MONTO   (AM),
    .ANCHO_BALANCE (AB),
    .COMISION_VAL  (FEE)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_de_tarjeta      (tipo_de_tarjeta),
    .pin                  (pin),
    .digito               (digito),
    .digito_stb           (digito_stb),
    .tipo_trans           (tipo_trans),
    .monto                (monto),
    .monto_stb            (monto_stb),
    .balance_actualizado  (balance_actualizado),
    .entregar_dinero      (entregar_dinero),
    .fondos_insuficientes (fondos_insuficientes),
    .pin_incorrecto       (pin_incorrecto),
    .comision             (comision),
    .advertencia          (advertencia),
    .bloqueo              (bloqueo),
    .balance              (balance)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              wd;
    int unsigned     m;
    longint unsigned bal;
    logic [4:0]      p;
  } vec_t;

  vec_t            tbl[6];
  int              checks = 0;
  int              failures = 0;
  longint unsigned m_bal;
  int              m_int;
  logic [15:0]     code;
  bit              wrong, done, e_act, e_ent, e_fon, e_com, wd;
  logic [AM-1:0]   mval;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // {balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto, comision}
  function automatic logic [4:0] pulses();
    return {balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto, comision};
  endfunction

  task automatic enter_pin(input logic [15:0] c);
    for (int i = 0; i < ND; i++) begin
      digito = c[4*(ND-1-i) +: 4];
      digito_stb = 1'b1;
      tick();
      digito_stb = 1'b0;
      tick();
    end
  endtask

  task automatic do_trans(input bit w, input logic [AM-1:0] m);
    monto = m;
    tipo_trans = w;
    monto_stb = 1'b1;
    tick();
    monto_stb = 1'b0;
    tick();
  endtask

  // transaction rules applied to the model balance with plain arithmetic
  task automatic model_trans(input bit w, input longint unsigned m, input bit foreign);
    longint unsigned fee;
    fee = (FEE_ON && foreign) ? longint'(FEE) : 64'd0;
    e_act = 1'b0; e_ent = 1'b0; e_fon = 1'b0; e_com = 1'b0;
    if (!w) begin
      if (m_bal + m >= fee) begin
        m_bal = (m_bal + m - fee > MAXB) ? MAXB : m_bal + m - fee;
        e_act = 1'b1;
        e_com = (fee != 0);
      end else begin
        e_fon = 1'b1;
      end
    end else begin
      if (m + fee <= m_bal) begin
        m_bal = m_bal - m - fee;
        e_act = 1'b1;
        e_ent = 1'b1;
        e_com = (fee != 0);
      end else begin
        e_fon = 1'b1;
      end
    end
  endtask

  task automatic trans_checked(input string name, input bit w, input logic [AM-1:0] m);
    do_trans(w, m);
    model_trans(w, longint'(m), tipo_de_tarjeta);
    chk({name, "_balance"}, balance, m_bal);
    chk({name, "_pulses"}, pulses(), {e_act, e_ent, e_fon, 1'b0, e_com});
  endtask

  initial begin
    rst = 1'b1; tarjeta_recibida = 1'b0; tipo_de_tarjeta = 1'b0; pin = 16'hD4DD;
    digito = 4'h0; digito_stb = 1'b0; tipo_trans = 1'b0; monto = '0; monto_stb = 1'b0;
    tbl[0] = '{wd: 1'b0, m: 1000,  bal: 1000,  p: 5'b10000};
    tbl[1] = '{wd: 1'b1, m: 1001,  bal: 1000,  p: 5'b00100};
    tbl[2] = '{wd: 1'b1, m: 1000,  bal: 0,     p: 5'b11000};
    tbl[3] = '{wd: 1'b1, m: 0,     bal: 0,     p: 5'b11000};
    tbl[4] = '{wd: 1'b0, m: 65535, bal: 65535, p: 5'b10000};
    tbl[5] = '{wd: 1'b1, m: 1,     bal: 65534, p: 5'b11000};

    // reset state
    tick(); tick();
    chk("reset_balance", balance, 0);
    chk("reset_pulses", pulses(), 0);
    chk("reset_bloqueo", bloqueo, 0);
    chk("reset_advertencia", advertencia, 0);
    rst = 1'b0;

    // foreign card, PIN D4DD, deposit 20000
    tipo_de_tarjeta = 1'b1; tarjeta_recibida = 1'b1; tick();
    enter_pin(16'hD4DD);
    chk("d4dd_pin_ok", pin_incorrecto, 0);
    do_trans(1'b0, 16'd20000);
    chk("d4dd_balance", balance, FEE_ON ? 19500 : 20000);
    chk("d4dd_actualizado", balance_actualizado, 1);
    chk("d4dd_comision", comision, FEE_ON);
    tick();
    chk("d4dd_pulses_one_cycle", pulses(), 0);
    tarjeta_recibida = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_again_balance", balance, 0);
    m_bal = 0; m_int = 0;

    // own card, table of transactions
    tipo_de_tarjeta = 1'b0; tarjeta_recibida = 1'b1; tick();
    enter_pin(16'hD4DD);
    for (int i = 0; i < 6; i++) begin
      do_trans(tbl[i].wd, AM'(tbl[i].m));
      chk($sformatf("tbl%0d_balance", i), balance, tbl[i].bal);
      chk($sformatf("tbl%0d_pulses", i), pulses(), tbl[i].p);
    end
    m_bal = 65534;

    // strobe held high counts once
    monto = 16'd5; tipo_trans = 1'b0; monto_stb = 1'b1;
    repeat (4) tick();
    monto_stb = 1'b0; tick();
    chk("held_strobe_balance", balance, 65539);
    m_bal = 65539;

    // digit strobe outside PIN entry is ignored; amounts still accepted
    digito = 4'h3; digito_stb = 1'b1; tick(); digito_stb = 1'b0; tick();
    trans_checked("after_stray_digit", 1'b0, 16'd1);

    // saturation at all-ones
    for (int i = 0; i < 17; i++) trans_checked($sformatf("sat%0d", i), 1'b0, 16'hFFFF);
    chk("sat_final", balance, MAXB);
    trans_checked("sat_withdraw", 1'b1, 16'hFFFF);
    tarjeta_recibida = 1'b0; tick();

    // wrong PINs, card removal keeps attempts, then lockout
    tarjeta_recibida = 1'b1; tick();
    enter_pin(16'h1111);
    chk("wrong1_pulse", pin_incorrecto, 1);
    chk("wrong1_adv", advertencia, 0);
    tick();
    chk("wrong1_one_cycle", pin_incorrecto, 0);
    digito = 4'hD; digito_stb = 1'b1; tick(); digito_stb = 1'b0; tick();
    digito = 4'h4; digito_stb = 1'b1; tick(); digito_stb = 1'b0; tick();
    tarjeta_recibida = 1'b0; tick(); tarjeta_recibida = 1'b1; tick();
    enter_pin(16'h1111);
    chk("wrong2_pulse", pin_incorrecto, 1);
    chk("wrong2_adv", advertencia, 1);
    digito = 4'hD; digito_stb = 1'b1; tick(); digito_stb = 1'b0; tick();
    digito = 4'h4; digito_stb = 1'b1; tick(); digito_stb = 1'b0; tick();
    tarjeta_recibida = 1'b0; tick(); tarjeta_recibida = 1'b1; tick();
    enter_pin(16'hD4DD);
    chk("reinsert_ok", pin_incorrecto, 0);
    chk("reinsert_adv_cleared", advertencia, 0);
    trans_checked("reinsert_deposit", 1'b0, 16'd7);
    tarjeta_recibida = 1'b0; tick(); tarjeta_recibida = 1'b1; tick();
    enter_pin(16'h1111);
    enter_pin(16'h1111);
    chk("lock_adv", advertencia, 1);
    enter_pin(16'h1111);
    chk("lock_bloqueo", bloqueo, 1);
    chk("lock_pulse", pin_incorrecto, 1);
    tarjeta_recibida = 1'b0; tick(); tick();
    tarjeta_recibida = 1'b1; tick();
    enter_pin(16'hD4DD);
    do_trans(1'b0, 16'd100);
    chk("locked_bloqueo_held", bloqueo, 1);
    chk("locked_balance", balance, m_bal);
    chk("locked_pulses", pulses(), 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("unlock_bloqueo", bloqueo, 0);
    chk("unlock_adv", advertencia, 0);
    m_bal = 0; m_int = 0;

    // reset during PROCESANDO
    tarjeta_recibida = 1'b0; tick(); tarjeta_recibida = 1'b1; tick();
    enter_pin(16'hD4DD);
    trans_checked("pre_rst_deposit", 1'b0, 16'd100);
    monto = 16'd50; tipo_trans = 1'b0; monto_stb = 1'b1; tick();
    monto_stb = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("midproc_rst_balance", balance, 0);
    chk("midproc_rst_pulses", pulses(), 0);
    do_trans(1'b0, 16'd9);
    chk("post_rst_amount_ignored", balance, 0);
    chk("post_rst_no_pulses", pulses(), 0);
    tarjeta_recibida = 1'b0; tick();
    m_bal = 0; m_int = 0;

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      tipo_de_tarjeta = 1'($urandom_range(0, 1));
      pin = 16'($urandom);
      tarjeta_recibida = 1'b1; tick();
      done = 1'b0;
      for (int a = 0; a < 4 && !done; a++) begin
        wrong = ($urandom_range(0, 2) == 0);
        code = pin;
        if (wrong) begin
          int b;
          b = int'($urandom_range(0, 15));
          code[b] = ~code[b];
        end
        enter_pin(code);
        if (wrong) begin
          m_int++;
          chk("rnd_wrong_pulse", pin_incorrecto, 1);
          chk("rnd_wrong_adv", advertencia, (m_int >= MAXI - 1) ? 1 : 0);
          chk("rnd_wrong_bloqueo", bloqueo, (m_int >= MAXI) ? 1 : 0);
          if (m_int >= MAXI) begin
            tarjeta_recibida = 1'b0; tick();
            chk("rnd_lock_held", bloqueo, 1);
            rst = 1'b1; tick(); rst = 1'b0;
            m_int = 0; m_bal = 0;
            chk("rnd_lock_rst_balance", balance, 0);
            done = 1'b1;
          end
        end else begin
          m_int = 0;
          chk("rnd_ok_pulse", pin_incorrecto, 0);
          chk("rnd_ok_adv", advertencia, 0);
          for (int t = 0; t < int'($urandom_range(1, 5)); t++) begin
            wd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
              0: mval = AM'($urandom_range(0, 1000));
              1: mval = 16'hFFFF;
              default: mval = AM'($urandom);
            endcase
            trans_checked("rnd_trans", wd, mval);
          end
          done = 1'b1;
        end
      end
      tarjeta_recibida = 1'b0; tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
